// File: rtl/spwm_pkg.sv
// Shared types and defaults for the SPWM carrier sequencer.
// The state encoding is common to the sequencer and anything that observes it.
package spwm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    TOP,
    FALL,
    BOT
  } state_e;

  localparam int WIDTH_DEF = 15;
  localparam int PEAK_DEF  = 15358;
  localparam int DWELL_DEF = 2;
  localparam int NSTEP_DEF = 5;
  localparam int CW_DEF    = 4;

  // Modulo-n increment used for the completed-period counter.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/spwm_carrier_seq_if.sv
// Peak reconfiguration port: valid/ready handshake carrying a new ramp peak.
interface spwm_carrier_seq_if #(
  parameter int WIDTH = 15
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_peak;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_peak, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_peak, output cfg_ready);
endinterface

// File: rtl/spwm_dwell_timer.sv
// Load/count-down timer; done is high once the loaded dwell has elapsed.
module spwm_dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Loading DWELL-1 makes done assert in the DWELL-th cycle after the load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(DWELL - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/spwm_carrier_seq.sv
// Triangular carrier sequencer: steers an external inc/dec counter pair, muxes their
// counts onto one carrier bus, dwells at the extremes and emits a step every NSTEP periods.
module spwm_carrier_seq
  import spwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PEAK  = PEAK_DEF,
  parameter int DWELL = DWELL_DEF,
  parameter int NSTEP = NSTEP_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] cnt_inc,
  input  logic [WIDTH-1:0] cnt_dec,
  spwm_carrier_seq_if.slave cfg,
  output logic             en_inc,
  output logic             en_dec,
  output logic [WIDTH-1:0] carrier,
  output logic             at_top,
  output logic             at_bot,
  output logic             step,
  output logic [CW-1:0]    period_cnt
);

  state_e           state_q, state_d;
  logic             en_inc_q, en_inc_d, en_dec_q, en_dec_d;
  logic [WIDTH-1:0] carrier_q, carrier_d, peak_q, peak_d;
  logic             at_top_q, at_top_d, at_bot_q, at_bot_d;
  logic             step_q, step_d, cfg_ready_q, cfg_ready_d;
  logic [CW-1:0]    period_q, period_d;
  logic             dwell_load, dwell_done, cfg_fire;

  spwm_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .load (dwell_load),
    .en   ((state_q == TOP) || (state_q == BOT)),
    .done (dwell_done)
  );

  assign cfg_fire = cfg.cfg_valid && cfg_ready_q;

  // Ready is only ever high in IDLE/BOT, so a new peak can never disturb a ramp in flight.
  always_comb begin
    state_d    = state_q;
    en_inc_d   = en_inc_q;
    en_dec_d   = en_dec_q;
    carrier_d  = carrier_q;
    peak_d     = peak_q;
    period_d   = period_q;
    step_d     = 1'b0;
    dwell_load = 1'b0;
    if (cfg_fire) begin
      peak_d = (cfg.cfg_peak == '0) ? WIDTH'(1) : cfg.cfg_peak;
    end
    case (state_q)
      IDLE: begin
        carrier_d = '0;
        if (run) begin
          state_d  = RISE;
          en_inc_d = 1'b1;
        end
      end
      RISE: begin
        carrier_d = cnt_inc;
        // >= rather than == so an incrementer that overshoots still terminates the ramp
        if (cnt_inc >= peak_q) begin
          state_d    = TOP;
          en_inc_d   = 1'b0;
          carrier_d  = peak_q;
          dwell_load = 1'b1;
        end
      end
      TOP: begin
        carrier_d = peak_q;
        if (dwell_done) begin
          state_d  = FALL;
          en_dec_d = 1'b1;
        end
      end
      FALL: begin
        carrier_d = cnt_dec;
        if (cnt_dec == '0) begin
          state_d    = BOT;
          en_dec_d   = 1'b0;
          carrier_d  = '0;
          dwell_load = 1'b1;
          period_d   = CW'(wrap_inc(int'(period_q), NSTEP));
          step_d     = (wrap_inc(int'(period_q), NSTEP) == 0);
        end
      end
      BOT: begin
        carrier_d = '0;
        if (dwell_done) begin
          if (run) begin
            state_d  = RISE;
            en_inc_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        en_inc_d  = 1'b0;
        en_dec_d  = 1'b0;
        carrier_d = '0;
      end
    endcase
    at_top_d    = (state_d == TOP);
    at_bot_d    = (state_d == BOT);
    cfg_ready_d = (state_d == IDLE) || (state_d == BOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_inc_q    <= 1'b0;
      en_dec_q    <= 1'b0;
      carrier_q   <= '0;
      peak_q      <= WIDTH'(PEAK);
      period_q    <= '0;
      at_top_q    <= 1'b0;
      at_bot_q    <= 1'b0;
      step_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_inc_q    <= en_inc_d;
      en_dec_q    <= en_dec_d;
      carrier_q   <= carrier_d;
      peak_q      <= peak_d;
      period_q    <= period_d;
      at_top_q    <= at_top_d;
      at_bot_q    <= at_bot_d;
      step_q      <= step_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign en_inc        = en_inc_q;
  assign en_dec        = en_dec_q;
  assign carrier       = carrier_q;
  assign at_top        = at_top_q;
  assign at_bot        = at_bot_q;
  assign step          = step_q;
  assign period_cnt    = period_q;
  assign cfg.cfg_ready = cfg_ready_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(en_inc_q && en_dec_q));

endmodule
